// File: rtl/score_keeper_bcd.sv
// BCD score keeper: time points every TICK_DIV cycles plus pipe bonuses while alive,
// score frozen on death with a high-score capture; restart begins a new round.
module score_keeper_bcd #(
  parameter int NUM_DIGITS = 3,
  parameter int TICK_DIV   = 13,
  parameter int WRAP_MODE  = 1
) (
  input  logic                    Clock,
  input  logic                    Reset,
  input  logic                    death,
  input  logic                    outofbounddeath,
  input  logic                    pipe_pass,
  input  logic                    restart,
  output logic [4*NUM_DIGITS-1:0] score_bcd,
  output logic [4*NUM_DIGITS-1:0] high_bcd,
  output logic                    new_high,
  output logic                    overflow,
  output logic                    alive
);

  localparam int W  = 4 * NUM_DIGITS;
  localparam int DW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(TICK_DIV - 1);
  localparam logic [W-1:0]  ALL_NINES = {NUM_DIGITS{4'h9}};

  typedef enum logic {
    PLAY = 1'b0,
    DEAD = 1'b1
  } state_t;

  state_t        state, state_nxt;
  logic [DW-1:0] div_q, div_nxt;
  logic [W-1:0]  score_nxt, high_nxt, sum;
  logic          new_high_nxt, overflow_nxt;
  logic          die, tick, carry_out;
  logic [1:0]    inc, carry;
  logic [4:0]    digit_sum;

  always_comb begin
    die  = death | outofbounddeath;
    tick = (state == PLAY) && (div_q == DIV_LAST);
    // Death on the same cycle suppresses both the time point and the bonus.
    inc  = 2'd0;
    if (state == PLAY && !die) inc = {1'b0, tick} + {1'b0, pipe_pass};
  end

  // Ripple BCD adder; inc <= 2 and digits <= 9 keep every digit sum below 20.
  always_comb begin
    carry     = inc;
    digit_sum = 5'd0;
    sum       = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      digit_sum = {1'b0, score_bcd[4*i +: 4]} + {3'b000, carry};
      if (digit_sum > 5'd9) begin
        sum[4*i +: 4] = 4'(digit_sum - 5'd10);
        carry         = 2'd1;
      end else begin
        sum[4*i +: 4] = digit_sum[3:0];
        carry         = 2'd0;
      end
    end
    carry_out = (carry != 2'd0);
  end

  always_comb begin
    state_nxt    = state;
    div_nxt      = div_q;
    score_nxt    = score_bcd;
    high_nxt     = high_bcd;
    new_high_nxt = new_high;
    overflow_nxt = 1'b0;
    case (state)
      PLAY: begin
        div_nxt = tick ? '0 : div_q + DW'(1);
        if (die) begin
          state_nxt = DEAD;
          if (score_bcd > high_bcd) begin
            high_nxt     = score_bcd;
            new_high_nxt = 1'b1;
          end
        end else if (inc != 2'd0) begin
          if (carry_out) begin
            overflow_nxt = 1'b1;
            score_nxt    = (WRAP_MODE != 0) ? sum : ALL_NINES;
          end else begin
            score_nxt = sum;
          end
        end
      end
      DEAD: begin
        if (restart) begin
          state_nxt    = PLAY;
          score_nxt    = '0;
          div_nxt      = '0;
          new_high_nxt = 1'b0;
        end
      end
      default: state_nxt = PLAY;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state     <= PLAY;
      div_q     <= '0;
      score_bcd <= '0;
      high_bcd  <= '0;
      new_high  <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      state     <= state_nxt;
      div_q     <= div_nxt;
      score_bcd <= score_nxt;
      high_bcd  <= high_nxt;
      new_high  <= new_high_nxt;
      overflow  <= overflow_nxt;
    end
  end

  assign alive = (state == PLAY);

endmodule

// File: tb/tb_score_keeper_bcd.sv
// Bench for score_keeper_bcd: a wrapping and a saturating instance share stimulus;
// directed table rows plus randomized cycles checked against an integer score model.
module tb_score_keeper_bcd;

  localparam int ND = 3;
  localparam int TD = 4;
  localparam int W  = 4 * ND;
  localparam int MAXV = 999;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1, dth = 1'b0, oob = 1'b0, pp = 1'b0, rs = 1'b0;
  logic [W-1:0] sc_w, hi_w, sc_s, hi_s;
  logic nh_w, ov_w, al_w, nh_s, ov_s, al_s;

  score_keeper_bcd #(.NUM_DIGITS(ND), .TICK_DIV(TD), .WRAP_MODE(1)) dut_wrap (
    .Clock(clk), .Reset(rst), .death(dth), .outofbounddeath(oob), .pipe_pass(pp),
    .restart(rs), .score_bcd(sc_w), .high_bcd(hi_w), .new_high(nh_w),
    .overflow(ov_w), .alive(al_w));

  score_keeper_bcd #(.NUM_DIGITS(ND), .TICK_DIV(TD), .WRAP_MODE(0)) dut_sat (
    .Clock(clk), .Reset(rst), .death(dth), .outofbounddeath(oob), .pipe_pass(pp),
    .restart(rs), .score_bcd(sc_s), .high_bcd(hi_s), .new_high(nh_s),
    .overflow(ov_s), .alive(al_s));

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: integer scores, index 0 = wrapping, 1 = saturating.
  int  m_sc[2], m_hi[2];
  bit  m_nh[2], m_ov[2];
  int  m_div;
  bit  m_play;

  function automatic logic [W-1:0] to_bcd(input int v);
    logic [W-1:0] b;
    int p;
    b = '0;
    p = 1;
    for (int i = 0; i < ND; i++) begin
      b[4*i +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    return b;
  endfunction

  task automatic model_step();
    int inc, s;
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        m_sc[k] = 0; m_hi[k] = 0; m_nh[k] = 0; m_ov[k] = 0;
      end
      m_div = 0; m_play = 1;
    end else if (m_play) begin
      inc = ((m_div == TD - 1) ? 1 : 0) + (pp ? 1 : 0);
      m_div = (m_div + 1) % TD;
      for (int k = 0; k < 2; k++) begin
        m_ov[k] = 0;
        if (dth || oob) begin
          if (m_sc[k] > m_hi[k]) begin
            m_hi[k] = m_sc[k];
            m_nh[k] = 1;
          end
        end else if (inc != 0) begin
          s = m_sc[k] + inc;
          if (s > MAXV) begin
            m_ov[k] = 1;
            m_sc[k] = (k == 0) ? s % (MAXV + 1) : MAXV;
          end else begin
            m_sc[k] = s;
          end
        end
      end
      if (dth || oob) m_play = 0;
    end else begin
      for (int k = 0; k < 2; k++) m_ov[k] = 0;
      if (rs) begin
        m_play = 1;
        m_div  = 0;
        for (int k = 0; k < 2; k++) begin
          m_sc[k] = 0; m_nh[k] = 0;
        end
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check("model score_w", 32'(sc_w), 32'(to_bcd(m_sc[0])));
    check("model score_s", 32'(sc_s), 32'(to_bcd(m_sc[1])));
    check("model high_w",  32'(hi_w), 32'(to_bcd(m_hi[0])));
    check("model high_s",  32'(hi_s), 32'(to_bcd(m_hi[1])));
    check("model new_high_w", 32'(nh_w), 32'(m_nh[0]));
    check("model new_high_s", 32'(nh_s), 32'(m_nh[1]));
    check("model overflow_w", 32'(ov_w), 32'(m_ov[0]));
    check("model overflow_s", 32'(ov_s), 32'(m_ov[1]));
    check("model alive_w", 32'(al_w), 32'(m_play));
    check("model alive_s", 32'(al_s), 32'(m_play));
  endtask

  typedef struct {
    logic r, d, o, p, s;
    int   reps;
    logic [W-1:0] e_sc, e_sc_s, e_hi;
    logic e_al, e_nh, e_ov, e_ov_s;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, d, o, p, s, input int n,
                     input logic [W-1:0] sc, scs, hi,
                     input logic al, nh, ov, ovs);
    vec_t v;
    v.r = r; v.d = d; v.o = o; v.p = p; v.s = s; v.reps = n;
    v.e_sc = sc; v.e_sc_s = scs; v.e_hi = hi;
    v.e_al = al; v.e_nh = nh; v.e_ov = ov; v.e_ov_s = ovs;
    vecs.push_back(v);
  endtask

  initial begin
    m_play = 1; m_div = 0;
    for (int k = 0; k < 2; k++) begin
      m_sc[k] = 0; m_hi[k] = 0; m_nh[k] = 0; m_ov[k] = 0;
    end

    //   r  d  o  p  s  reps  score   score_s high    al nh ov ov_s
    add(1, 0, 0, 0, 0,   1, 12'h000, 12'h000, 12'h000, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0,  12, 12'h003, 12'h003, 12'h000, 1, 0, 0, 0);
    add(0, 0, 0, 1, 0,   3, 12'h006, 12'h006, 12'h000, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0,   1, 12'h007, 12'h007, 12'h000, 1, 0, 0, 0);
    add(0, 0, 0, 1, 0,   1, 12'h008, 12'h008, 12'h000, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0,   2, 12'h008, 12'h008, 12'h000, 1, 0, 0, 0);
    add(0, 0, 0, 1, 0,   1, 12'h010, 12'h010, 12'h000, 1, 0, 0, 0);
    add(0, 0, 0, 1, 0,  88, 12'h120, 12'h120, 12'h000, 1, 0, 0, 0);
    add(0, 0, 0, 1, 0,   3, 12'h123, 12'h123, 12'h000, 1, 0, 0, 0);
    add(0, 1, 0, 0, 0,   1, 12'h123, 12'h123, 12'h123, 0, 1, 0, 0);
    add(0, 0, 0, 0, 0,  20, 12'h123, 12'h123, 12'h123, 0, 1, 0, 0);
    add(0, 0, 0, 0, 1,   1, 12'h000, 12'h000, 12'h123, 1, 0, 0, 0);
    add(0, 0, 0, 1, 0,  40, 12'h050, 12'h050, 12'h123, 1, 0, 0, 0);
    add(0, 0, 1, 0, 0,   1, 12'h050, 12'h050, 12'h123, 0, 0, 0, 0);
    add(0, 0, 0, 0, 1,   1, 12'h000, 12'h000, 12'h123, 1, 0, 0, 0);
    add(0, 0, 0, 1, 0,   4, 12'h005, 12'h005, 12'h123, 1, 0, 0, 0);
    add(0, 0, 0, 0, 1,   1, 12'h005, 12'h005, 12'h123, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0,   3, 12'h006, 12'h006, 12'h123, 1, 0, 0, 0);
    add(0, 1, 0, 0, 0,   1, 12'h006, 12'h006, 12'h123, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0,   1, 12'h000, 12'h000, 12'h000, 1, 0, 0, 0);
    add(0, 1, 0, 0, 0,   1, 12'h000, 12'h000, 12'h000, 0, 0, 0, 0);
    add(0, 1, 0, 0, 1,   1, 12'h000, 12'h000, 12'h000, 1, 0, 0, 0);
    add(0, 1, 0, 0, 0,   1, 12'h000, 12'h000, 12'h000, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0,   1, 12'h000, 12'h000, 12'h000, 1, 0, 0, 0);
    add(0, 0, 0, 1, 0, 796, 12'h995, 12'h995, 12'h000, 1, 0, 0, 0);
    add(0, 0, 0, 1, 0,   3, 12'h998, 12'h998, 12'h000, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0,   1, 12'h999, 12'h999, 12'h000, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0,   3, 12'h999, 12'h999, 12'h000, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0,   1, 12'h000, 12'h999, 12'h000, 1, 0, 1, 1);
    add(0, 0, 0, 0, 0,   3, 12'h000, 12'h999, 12'h000, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0,   1, 12'h001, 12'h999, 12'h000, 1, 0, 0, 1);
    add(0, 0, 0, 1, 0,   1, 12'h002, 12'h999, 12'h000, 1, 0, 0, 1);

    foreach (vecs[i]) begin
      rst = vecs[i].r; dth = vecs[i].d; oob = vecs[i].o; pp = vecs[i].p; rs = vecs[i].s;
      repeat (vecs[i].reps) cycle();
      check($sformatf("row%0d score_w", i), 32'(sc_w), 32'(vecs[i].e_sc));
      check($sformatf("row%0d score_s", i), 32'(sc_s), 32'(vecs[i].e_sc_s));
      check($sformatf("row%0d high_w", i), 32'(hi_w), 32'(vecs[i].e_hi));
      check($sformatf("row%0d high_s", i), 32'(hi_s), 32'(vecs[i].e_hi));
      check($sformatf("row%0d alive", i), 32'(al_w), 32'(vecs[i].e_al));
      check($sformatf("row%0d new_high", i), 32'(nh_w), 32'(vecs[i].e_nh));
      check($sformatf("row%0d overflow_w", i), 32'(ov_w), 32'(vecs[i].e_ov));
      check($sformatf("row%0d overflow_s", i), 32'(ov_s), 32'(vecs[i].e_ov_s));
    end

    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 499) == 0);
      dth = ($urandom_range(0, 39) == 0);
      oob = ($urandom_range(0, 59) == 0);
      pp  = ($urandom_range(0, 2) == 0);
      rs  = ($urandom_range(0, 3) == 0);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
